// File: rtl/vp_iqueue_fifo_fwft.sv
// vp_iqueue_fifo_fwft: first-word-fall-through instruction queue over a sync-write/async-read RAM.
// Optional feature macro VP_IQUEUE_PEEK_EN adds a head+1 peek port (nxt_valid/nxt_data).
`ifndef COE_WIDTH
`define COE_WIDTH 32
`endif
`ifndef IQUEUE_DEPTH
`define IQUEUE_DEPTH 16
`endif

module vp_iqueue_fifo_fwft #(
   parameter int DWIDTH   = `COE_WIDTH,
   parameter int DEPTH    = `IQUEUE_DEPTH,
   parameter int AWIDTH   = $clog2(DEPTH),
   parameter int AFULL_TH = DEPTH - 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DWIDTH-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] out_data,
   output logic [AWIDTH:0]   count,
   output logic              almost_full
`ifdef VP_IQUEUE_PEEK_EN
   ,
   output logic              nxt_valid,
   output logic [DWIDTH-1:0] nxt_data
`endif
);

   localparam logic [AWIDTH:0]   FULL_CNT  = (AWIDTH+1)'(DEPTH);
   localparam logic [AWIDTH:0]   AFULL_CNT = (AWIDTH+1)'(AFULL_TH);
   localparam logic [AWIDTH-1:0] LAST_PTR  = AWIDTH'(DEPTH - 1);

   logic [DWIDTH-1:0] ram_q [DEPTH];

   logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [AWIDTH:0]   cnt_q, cnt_d;
   logic              afull_q, afull_d;
   logic              push_s, pop_s, ram_wr_s;

   // Explicit wrap at DEPTH-1 so non-power-of-two depths index only real entries.
   function automatic logic [AWIDTH-1:0] ptr_inc(input logic [AWIDTH-1:0] ptr);
      logic [AWIDTH-1:0] nxt;
      if (ptr == LAST_PTR) begin
         nxt = '0;
      end else begin
         nxt = ptr + AWIDTH'(1);
      end
      return nxt;
   endfunction

   // Handshakes derive only from registered occupancy (and rst_n for in_ready).
   always_comb begin
      in_ready  = rst_n & (cnt_q != FULL_CNT);
      out_valid = (cnt_q != '0);
      push_s    = in_valid & in_ready;
      pop_s     = out_valid & out_ready;
      ram_wr_s  = push_s & ~flush;
   end

   // Next-state for pointers, occupancy and the registered almost-full flag.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + (AWIDTH+1)'(1);
            2'b01:   cnt_d = cnt_q - (AWIDTH+1)'(1);
            default: cnt_d = cnt_q;
         endcase
      end
      afull_d = (cnt_d >= AFULL_CNT);
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         afull_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         afull_q  <= afull_d;
      end
   end

   // Storage array: written on accepted pushes, never reset or cleared.
   always_ff @(posedge clk) begin
      if (ram_wr_s) begin
         ram_q[wr_ptr_q] <= in_data;
      end
   end

   always_comb begin
      out_data    = ram_q[rd_ptr_q];
      count       = cnt_q;
      almost_full = afull_q;
   end

`ifdef VP_IQUEUE_PEEK_EN
   // Second read port lets decode look one instruction ahead.
   always_comb begin
      nxt_data  = ram_q[ptr_inc(rd_ptr_q)];
      nxt_valid = (cnt_q >= (AWIDTH+1)'(2));
   end
`endif

endmodule

// File: tb/tb_vp_iqueue_fifo_fwft.sv
// Bench for vp_iqueue_fifo_fwft: DEPTH=4 and DEPTH=5 instances on shared stimulus,
// a hand-derived vector table, corner-case sequences and random traffic vs. queue models.
module tb_vp_iqueue_fifo_fwft;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, flush, in_valid, out_ready;
   logic [7:0] in_data;

   logic       in_ready4, out_valid4, af4;
   logic [7:0] out_data4;
   logic [2:0] count4;
   logic       in_ready5, out_valid5, af5;
   logic [7:0] out_data5;
   logic [3:0] count5;
`ifdef VP_IQUEUE_PEEK_EN
   logic       nxt_valid4, nxt_valid5;
   logic [7:0] nxt_data4, nxt_data5;
`endif

   vp_iqueue_fifo_fwft #(.DWIDTH(8), .DEPTH(4), .AFULL_TH(2)) dut4 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
      .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
      .count(count4), .almost_full(af4)
`ifdef VP_IQUEUE_PEEK_EN
      , .nxt_valid(nxt_valid4), .nxt_data(nxt_data4)
`endif
   );

   vp_iqueue_fifo_fwft #(.DWIDTH(8), .DEPTH(5), .AFULL_TH(2)) dut5 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready5), .in_data(in_data),
      .out_valid(out_valid5), .out_ready(out_ready), .out_data(out_data5),
      .count(count5), .almost_full(af5)
`ifdef VP_IQUEUE_PEEK_EN
      , .nxt_valid(nxt_valid5), .nxt_data(nxt_data5)
`endif
   );

   int nvec = 0;
   int nerr = 0;
   logic [7:0] m4[$];
   logic [7:0] m5[$];
   logic       last_blk = 1'b0;
   logic [7:0] last_d = 8'h00;

   typedef struct {
      logic       r, f, iv;
      logic [7:0] d;
      logic       orr;
      logic [2:0] cnt;
      logic       af, ov;
      logic [7:0] od;
   } vec_t;
   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_state();
      chk("count4", 32'(count4), m4.size());
      chk("out_valid4", 32'(out_valid4), 32'(m4.size() != 0));
      chk("afull4", 32'(af4), 32'(m4.size() >= 2));
      if (m4.size() > 0) chk("out_data4", 32'(out_data4), 32'(m4[0]));
      chk("count5", 32'(count5), m5.size());
      chk("out_valid5", 32'(out_valid5), 32'(m5.size() != 0));
      chk("afull5", 32'(af5), 32'(m5.size() >= 2));
      if (m5.size() > 0) chk("out_data5", 32'(out_data5), 32'(m5[0]));
`ifdef VP_IQUEUE_PEEK_EN
      chk("nxt_valid4", 32'(nxt_valid4), 32'(m4.size() >= 2));
      if (m4.size() >= 2) chk("nxt_data4", 32'(nxt_data4), 32'(m4[1]));
      chk("nxt_valid5", 32'(nxt_valid5), 32'(m5.size() >= 2));
      if (m5.size() >= 2) chk("nxt_data5", 32'(nxt_data5), 32'(m5[1]));
`endif
   endtask

   // One clock: drive inputs, check in_ready, advance the models at the edge, check state.
   task automatic cycle(input logic r, input logic f, input logic iv, input logic [7:0] d,
                        input logic orr);
      logic p4, p5, o4, o5;
      rst_n = r; flush = f; in_valid = iv; in_data = d; out_ready = orr;
      #1;
      chk("in_ready4", 32'(in_ready4), 32'(r && m4.size() != 4));
      chk("in_ready5", 32'(in_ready5), 32'(r && m5.size() != 5));
      last_blk = iv && (!r || m4.size() == 4 || m5.size() == 5);
      last_d   = d;
      @(posedge clk);
      p4 = iv && r && (m4.size() < 4);
      p5 = iv && r && (m5.size() < 5);
      o4 = orr && (m4.size() > 0);
      o5 = orr && (m5.size() > 0);
      if (!r || f) begin
         m4.delete();
         m5.delete();
      end else begin
         if (o4) void'(m4.pop_front());
         if (p4) m4.push_back(d);
         if (o5) void'(m5.pop_front());
         if (p5) m5.push_back(d);
      end
      @(negedge clk);
      check_state();
   endtask

   initial begin
      // Reset with in_valid held, then fill A1..A4 and drain (DEPTH=4, AFULL_TH=2).
      tbl[0] = '{1'b0, 1'b0, 1'b1, 8'hEE, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 8'hEE, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 3'd1, 1'b0, 1'b1, 8'hA1};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 8'hA2, 1'b0, 3'd2, 1'b1, 1'b1, 8'hA1};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 8'hA3, 1'b0, 3'd3, 1'b1, 1'b1, 8'hA1};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 8'hA4, 1'b0, 3'd4, 1'b1, 1'b1, 8'hA1};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 1'b1, 8'hA2};
      tbl[7] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b1, 8'hA3};
      tbl[8] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 1'b1, 8'hA4};
      tbl[9] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00};

      for (int i = 0; i < 10; i++) begin
         cycle(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].orr);
         chk("tbl_count4", 32'(count4), 32'(tbl[i].cnt));
         chk("tbl_afull4", 32'(af4), 32'(tbl[i].af));
         chk("tbl_out_valid4", 32'(out_valid4), 32'(tbl[i].ov));
         if (tbl[i].ov) chk("tbl_out_data4", 32'(out_data4), 32'(tbl[i].od));
         if (i == 5) chk("tbl_full_in_ready4", 32'(in_ready4), 32'd0);
      end

      // Steady push+pop at count 2 across the pointer wrap.
      cycle(1'b1, 1'b0, 1'b1, 8'hB0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 8'hB1, 1'b0);
      for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b1, 8'hC0 + 8'(i), 1'b1);
      chk("wrap_count5", 32'(count5), 32'd2);
      chk("wrap_data5", 32'(out_data5), 32'hCA);

      // Full boundary: pop and push requested while full -> pop only.
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 8'hD0 + 8'(i), 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 8'hD4, 1'b1);
      chk("full_pop_count4", 32'(count4), 32'd3);
      chk("full_pop_count5", 32'(count5), 32'd4);
      cycle(1'b1, 1'b0, 1'b1, 8'hD4, 1'b0);
      chk("full_push_count4", 32'(count4), 32'd4);
      chk("full_push_count5", 32'(count5), 32'd5);

      // Empty: push with out_ready must not bypass.
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 8'h55, 1'b1);
      chk("empty_count4", 32'(count4), 32'd1);
      chk("empty_data4", 32'(out_data4), 32'h55);
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

      // Flush overriding push and pop at count 3.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 8'hE1 + 8'(i), 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 8'hE4, 1'b1);
      chk("flush_count4", 32'(count4), 32'd0);
      chk("flush_out_valid4", 32'(out_valid4), 32'd0);
      cycle(1'b1, 1'b0, 1'b1, 8'hF1, 1'b0);
      chk("post_flush_data4", 32'(out_data4), 32'hF1);
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

      // Peek sequence, repeated from shifted pointer positions.
      for (int rep = 0; rep < 3; rep++) begin
         cycle(1'b1, 1'b0, 1'b1, 8'h10, 1'b0);
         cycle(1'b1, 1'b0, 1'b1, 8'h20, 1'b0);
         cycle(1'b1, 1'b0, 1'b1, 8'h30, 1'b0);
         chk("peek_head4", 32'(out_data4), 32'h10);
`ifdef VP_IQUEUE_PEEK_EN
         chk("peek_nxt4", 32'(nxt_data4), 32'h20);
         chk("peek_nxt5", 32'(nxt_data5), 32'h20);
`endif
         cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
         cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
         cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      end

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 400; i++) begin
         logic r, f, iv, orr;
         logic [7:0] d;
         r   = ($urandom_range(63) != 0);
         f   = ($urandom_range(31) == 0);
         iv  = ($urandom_range(99) < 60);
         orr = ($urandom_range(99) < 50);
         d   = 8'($urandom);
         if (last_blk) begin
            iv = 1'b1;
            d  = last_d;
         end
         cycle(r, f, iv, d, orr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/vp_iqueue_fifo_fwft.md
# vp_iqueue_fifo_fwft

Parametrised first-word-fall-through FIFO for the VP sequencer instruction queue. It wraps a two-port RAM with a synchronous write and an asynchronous read, and adds:
- write and read pointers with explicit wrap, so any depth is supported;
- valid/ready handshakes on both sides;
- an occupancy count, an almost-full flag and a synchronous flush.

It sits between the instruction fetch path (producer) and the sequencer decode stage (consumer).

## Interface
- DWIDTH, default `COE_WIDTH, entry width in bits
- DEPTH, default `IQUEUE_DEPTH, number of entries; any value ≥ 2, power of two not required
- AWIDTH, default $clog2(DEPTH), pointer width
- AFULL_TH, default DEPTH-2, almost_full asserts when count ≥ AFULL_TH; legal range 1..DEPTH
- clk  in  1  sole clock, all state updates on the rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  discard all entries
- in_valid  in  1  producer has data
- in_ready  out  1  FIFO accepts data
- in_data  in  DWIDTH  write data
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head
- out_data  out  DWIDTH  head entry, combinational from RAM
- count  out  AWIDTH+1  current occupancy, 0..DEPTH
- almost_full  out  1  count ≥ AFULL_TH
- nxt_valid  out  1  entry head+1 valid (only with VP_IQUEUE_PEEK_EN)
- nxt_data  out  DWIDTH  entry head+1 (only with VP_IQUEUE_PEEK_EN)

## Operation
- Registered state:
  - wr_ptr and rd_ptr, each 0..DEPTH-1;
  - cnt, 0..DEPTH.
- Pointer wrap: a pointer at DEPTH-1 increments to 0. No modulo-2^AWIDTH wrap is allowed.
- push = in_valid & in_ready. Writes in_data to RAM[wr_ptr], then wr_ptr advances.
- pop = out_valid & out_ready. rd_ptr advances.
- Handshake outputs:
  - in_ready = rst_n & (cnt != DEPTH);
  - out_valid = (cnt != 0);
  - out_data = RAM[rd_ptr], which is meaningful only when out_valid = 1.
- cnt update rules:
  - push only: cnt+1;
  - pop only: cnt-1;
  - push and pop together: cnt unchanged, both pointers advance.
- Full (cnt = DEPTH): in_ready = 0. A pop in the same cycle does not enable a push; there is no full-throughput pass-through when full.
- Empty (cnt = 0): out_valid = 0. A push and out_ready in the same cycle do not bypass, and the data appears on the next cycle.
- Flush:
  - next state is wr_ptr = rd_ptr = cnt = 0;
  - flush overrides any push or pop in the same cycle, and the RAM write is suppressed;
  - RAM contents are not cleared.
- Reset (rst_n = 0 at an edge):
  - same register values as flush;
  - in_ready is held at 0 for the whole time rst_n is low;
  - the RAM is not reset.
- Producer protocol: in_data must stay stable while in_valid = 1 and in_ready = 0. The bench checks this; the block does not enforce it.

## Timing
- Write-to-read latency is 1 cycle. A push at edge N makes the entry visible on out_data/out_valid after edge N, with no extra register stage.
- Throughput: 1 push and 1 pop per cycle whenever 0 < cnt < DEPTH.
- count and almost_full are registered, reflecting state after the last edge. There is no combinational path from in_valid or out_ready to them.
- in_ready depends only on registered cnt and rst_n. out_valid depends only on cnt.
- Output values after reset deasserts:
  - in_ready = 1, out_valid = 0, count = 0;
  - almost_full = 0 (given AFULL_TH ≥ 1), nxt_valid = 0;
  - out_data and nxt_data are undefined.

## Configuration
- Macro: VP_IQUEUE_PEEK_EN.
- Defined:
  - a second asynchronous read port on the RAM;
  - nxt_data = RAM[rd_ptr+1 with wrap];
  - nxt_valid = (cnt ≥ 2);
  - this lets decode pre-examine the following instruction.
- Undefined:
  - nxt_valid and nxt_data are removed from the port list;
  - the RAM has a single read port.

## Test plan
- Reset with DEPTH = 4: hold rst_n = 0 for 2 cycles with in_valid = 1 -> in_ready = 0 during reset, count = 0 and out_valid = 0 after it, no entry written.
- Fill then drain, DEPTH = 4, AFULL_TH = 2:
  - push 0xA1..0xA4 on back-to-back cycles -> count 1,2,3,4, almost_full from count = 2, in_ready = 0 at 4;
  - drain -> out_data 0xA1..0xA4 in order.
- Non-power-of-two wrap, DEPTH = 5: hold steady push and pop for 12 cycles starting at cnt = 2 -> both pointers wrap 4→0, data order is preserved, count stays 2.
- Full boundary: at cnt = DEPTH, assert out_ready and in_valid together -> one pop, no push, count = DEPTH-1. A push succeeds on the next cycle.
- Empty and flush:
  - push 0x55 when empty with out_ready = 1 -> out_valid = 0 that cycle, 0x55 presented the next cycle;
  - flush with push and pop asserted at cnt = 3 -> count = 0, out_valid = 0, pushed data discarded.
- Peek (VP_IQUEUE_PEEK_EN): push 0x10, 0x20, 0x30 -> nxt_valid = 1 with nxt_data = 0x20 while out_data = 0x10. After two pops, nxt_valid = 0. Repeat across the pointer wrap.
